mac_seq_ctrl: RTL and testbench

//   Sequencer for the FP MAC datapath (multiply -> align/add -> normalize -> round).

---
 rtl/mac_pkg.sv | 20 ++
 rtl/mac_lat_timer.sv | 39 +++
 rtl/mac_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared constants for the FP MAC sequencer, datapath and status registers.
package mac_pkg;

    // Element precision encodings.
    localparam logic OP_HALF   = 1'b0;
    localparam logic OP_SINGLE = 1'b1;

    // Sequencer states.
    localparam int unsigned ST_W    = 2;
    localparam logic [1:0]  ST_IDLE = 2'd0;
    localparam logic [1:0]  ST_RUN  = 2'd1;
    localparam logic [1:0]  ST_HOLD = 2'd2;

    // Sticky error bit positions.
    localparam int unsigned ERR_W       = 3;
    localparam int unsigned ERR_ORPHAN  = 0;
    localparam int unsigned ERR_RESTART = 1;
    localparam int unsigned ERR_OPMIS   = 2;

endpackage

// File: rtl/mac_lat_timer.sv
// Datapath trip timer: counts cycles since issue, with the issue cycle itself as 0.
module mac_lat_timer #(
    parameter int unsigned LAT = 4,
    parameter int unsigned TW  = $clog2(LAT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic          en_i,
    output logic [TW-1:0] cnt_o,
    output logic          done_o
);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Next count: restart at issue, otherwise advance and park at LAT.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = TW'(1);
        end else if (en_i && (cnt_q != TW'(LAT))) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign done_o = en_i && (cnt_q == TW'(LAT - 1));

endmodule

// File: rtl/mac_seq_ctrl.sv
// FP MAC sequencer: issues one chain element at a time, times its trip through the
// datapath, steers accumulator feedback and presents chain results on valid/ready.
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter int unsigned LAT   = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic             in_first,
    input  logic             in_last,
    output logic             dp_issue,
    output logic             dp_op,
    output logic             dp_acc_zero,
    output logic             dp_acc_we,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_op,
    output logic [CNT_W-1:0] chain_cnt,
    output logic [ERR_W-1:0] err,
    input  logic             err_clr,
    output logic             busy
);

    localparam int unsigned TW = $clog2(LAT + 1);

    logic [ST_W-1:0]  state_q, state_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             chain_open_q, chain_open_d;
    logic             chain_op_q, chain_op_d;
    logic [CNT_W-1:0] chain_cnt_q, chain_cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             last_q, last_d;

    logic             issue_c;
    logic             new_chain_c;
    logic             acc_we_c;
    logic [TW-1:0]    timer_cnt;
    logic             timer_done;

    assign issue_c = in_valid && in_ready_q;

    mac_lat_timer #(
        .LAT (LAT),
        .TW  (TW)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (issue_c),
        .en_i   (state_q == ST_RUN),
        .cnt_o  (timer_cnt),
        .done_o (timer_done)
    );

    // Next-state, chain bookkeeping and error detection.
    always_comb begin
        state_d      = state_q;
        chain_open_d = chain_open_q;
        chain_op_d   = chain_op_q;
        chain_cnt_d  = chain_cnt_q;
        last_d       = last_q;
        err_d        = err_clr ? '0 : err_q;
        new_chain_c  = 1'b0;
        acc_we_c     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (issue_c) begin
                    state_d = ST_RUN;
                    last_d  = in_last;
                    if (in_first || !chain_open_q) begin
                        new_chain_c  = 1'b1;
                        chain_op_d   = in_op;
                        chain_cnt_d  = CNT_W'(1);
                        chain_open_d = 1'b1;
                        if (!in_first) begin
                            err_d[ERR_ORPHAN] = 1'b1;
                        end else if (chain_open_q) begin
                            err_d[ERR_RESTART] = 1'b1;
                        end
                    end else begin
                        if (chain_cnt_q != '1) begin
                            chain_cnt_d = chain_cnt_q + CNT_W'(1);
                        end
                        if (in_op != chain_op_q) begin
                            err_d[ERR_OPMIS] = 1'b1;
                        end
                    end
                end
            end
            ST_RUN: begin
                if (timer_done) begin
                    acc_we_c = 1'b1;
                    if (last_q) begin
                        chain_open_d = 1'b0;
                        state_d      = ST_HOLD;
                    end
                end else if (timer_cnt == TW'(LAT)) begin
                    // One settle cycle so feedback is stable before the next accept.
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and status registers; handshake outputs are registered from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            chain_open_q <= 1'b0;
            chain_op_q   <= OP_HALF;
            chain_cnt_q  <= '0;
            err_q        <= '0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= (state_d == ST_IDLE);
            out_valid_q  <= (state_d == ST_HOLD);
            chain_open_q <= chain_open_d;
            chain_op_q   <= chain_op_d;
            chain_cnt_q  <= chain_cnt_d;
            err_q        <= err_d;
            last_q       <= last_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign dp_issue    = issue_c;
    assign dp_acc_zero = new_chain_c;
    assign dp_op       = new_chain_c ? in_op : chain_op_q;
    assign dp_acc_we   = acc_we_c;
    assign out_valid   = out_valid_q;
    assign out_op      = chain_op_q;
    assign chain_cnt   = chain_cnt_q;
    assign err         = err_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with LAT=4.
module tb_mac_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_op = 1'b0;
    logic        in_first = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic        err_clr = 1'b0;
    logic        in_ready, dp_issue, dp_op, dp_acc_zero, dp_acc_we;
    logic        out_valid, out_op, busy;
    logic [15:0] chain_cnt;
    logic [2:0]  err;

    int n_chk = 0;
    int n_pass = 0;

    // Per-chain observations filled by drive_chain.
    int   iss_t [8];
    logic iss_zero [8];
    logic iss_dpop [8];
    int   we_cnt, ov_t, ov_end_t, rdy_back_t;
    logic we_dpop;
    logic [2:0] err_at1;

    always #5 clk = ~clk;

    mac_seq_ctrl #(.LAT(4), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_first    (in_first),
        .in_last     (in_last),
        .dp_issue    (dp_issue),
        .dp_op       (dp_op),
        .dp_acc_zero (dp_acc_zero),
        .dp_acc_we   (dp_acc_we),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op      (out_op),
        .chain_cnt   (chain_cnt),
        .err         (err),
        .err_clr     (err_clr),
        .busy        (busy)
    );

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: runs a chain for a fixed number of cycles, recording events.
    task automatic drive_chain(input int n, input logic [7:0] ops, input logic [7:0] firsts,
                               input logic [7:0] lasts, input int cycles, input int rdy_t,
                               input logic clr0);
        int k;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            iss_t[i] = -1;
            iss_zero[i] = 1'bx;
            iss_dpop[i] = 1'bx;
        end
        we_cnt = 0; ov_t = -1; ov_end_t = -1; rdy_back_t = -1;
        we_dpop = 1'bx; err_at1 = 3'bxxx;
        for (int t = 0; t < cycles; t++) begin
            next();
            in_valid  = (k < n);
            in_first  = firsts[k[2:0]];
            in_last   = lasts[k[2:0]];
            in_op     = ops[k[2:0]];
            err_clr   = clr0 && (k == 0);
            out_ready = (t == rdy_t);
            #1;
            if (dp_issue && k < 8) begin
                iss_t[k[2:0]] = t;
                iss_zero[k[2:0]] = dp_acc_zero;
                iss_dpop[k[2:0]] = dp_op;
                k++;
            end
            if (dp_acc_we) begin
                we_cnt++;
                we_dpop = dp_op;
            end
            if (out_valid && ov_t < 0) ov_t = t;
            if (ov_t >= 0 && t > ov_t && !out_valid && ov_end_t < 0) ov_end_t = t;
            if (ov_t >= 0 && t > ov_t && in_ready && rdy_back_t < 0) rdy_back_t = t;
            if (t == 1) err_at1 = err;
        end
        in_valid = 1'b0; err_clr = 1'b0; out_ready = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        next();
        out_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1;
        #3;
        n_chk++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else n_pass++;
        n_chk++; if (dp_issue !== 1'b0) $display("FAIL rst_dp_issue: got %b want 0", dp_issue); else n_pass++;
        n_chk++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL rst_busy_ov: got %b%b want 00", busy, out_valid); else n_pass++;
        n_chk++; if (chain_cnt !== 16'd0 || err !== 3'd0) $display("FAIL rst_cnt_err: got %0d/%b want 0/000", chain_cnt, err); else n_pass++;
        in_valid = 1'b0;
        next();
        rst_n = 1'b1;
        next();
        n_chk++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int we_seen;
        we_seen = 0;
        in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1; in_op = 1'b1;
        #1;
        n_chk++; if (dp_issue !== 1'b1) $display("FAIL mid_issue: got %b want 1", dp_issue); else n_pass++;
        next();
        in_valid = 1'b0;
        #1;
        n_chk++; if (busy !== 1'b1) $display("FAIL mid_busy: got %b want 1", busy); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_chk++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) $display("FAIL mid_rst_outs: got busy=%b rdy=%b ov=%b want 000", busy, in_ready, out_valid); else n_pass++;
        n_chk++; if (chain_cnt !== 16'd0) $display("FAIL mid_rst_cnt: got %0d want 0", chain_cnt); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            next();
            if (dp_acc_we) we_seen++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            next();
            if (dp_acc_we || out_valid) we_seen++;
        end
        n_chk++; if (we_seen !== 0) $display("FAIL mid_no_acc_we: got %0d events want 0", we_seen); else n_pass++;
        n_chk++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL mid_idle: got rdy=%b busy=%b want 1 0", in_ready, busy); else n_pass++;
    endtask

    task automatic test_single_chain();
        drive_chain(1, 8'h01, 8'h01, 8'h01, 10, 6, 1'b0);
        n_chk++; if (iss_t[0] !== 0) $display("FAIL single_issue_t: got %0d want 0", iss_t[0]); else n_pass++;
        n_chk++; if (iss_zero[0] !== 1'b1 || iss_dpop[0] !== 1'b1) $display("FAIL single_zero_op: got %b%b want 11", iss_zero[0], iss_dpop[0]); else n_pass++;
        n_chk++; if (we_cnt !== 1) $display("FAIL single_we_cnt: got %0d want 1", we_cnt); else n_pass++;
        n_chk++; if (ov_t !== 4) $display("FAIL single_ov_t: got %0d want 4", ov_t); else n_pass++;
        n_chk++; if (ov_end_t !== 7 || rdy_back_t !== 7) $display("FAIL single_release: got ov_end=%0d rdy=%0d want 7 7", ov_end_t, rdy_back_t); else n_pass++;
        n_chk++; if (chain_cnt !== 16'd1 || out_op !== 1'b1) $display("FAIL single_cnt_op: got %0d/%b want 1/1", chain_cnt, out_op); else n_pass++;
    endtask

    task automatic test_half_chain();
        drive_chain(3, 8'h00, 8'h01, 8'h04, 16, -1, 1'b0);
        n_chk++; if (iss_t[0] !== 0 || iss_t[1] !== 5 || iss_t[2] !== 10) $display("FAIL half_issue_t: got %0d,%0d,%0d want 0,5,10", iss_t[0], iss_t[1], iss_t[2]); else n_pass++;
        n_chk++; if ({iss_zero[0], iss_zero[1], iss_zero[2]} !== 3'b100) $display("FAIL half_acc_zero: got %b%b%b want 100", iss_zero[0], iss_zero[1], iss_zero[2]); else n_pass++;
        n_chk++; if (we_cnt !== 3) $display("FAIL half_we_cnt: got %0d want 3", we_cnt); else n_pass++;
        n_chk++; if (ov_t !== 14) $display("FAIL half_ov_t: got %0d want 14", ov_t); else n_pass++;
        n_chk++; if (chain_cnt !== 16'd3 || out_op !== 1'b0 || err !== 3'b000) $display("FAIL half_status: got cnt=%0d op=%b err=%b want 3 0 000", chain_cnt, out_op, err); else n_pass++;
        drain();
    endtask

    task automatic test_op_mismatch();
        drive_chain(2, 8'h02, 8'h01, 8'h02, 11, -1, 1'b0);
        n_chk++; if (iss_t[1] !== 5 || iss_zero[1] !== 1'b0) $display("FAIL opmis_issue: got t=%0d zero=%b want 5 0", iss_t[1], iss_zero[1]); else n_pass++;
        n_chk++; if (iss_dpop[1] !== 1'b0 || we_dpop !== 1'b0) $display("FAIL opmis_dp_op: got %b/%b want 0/0", iss_dpop[1], we_dpop); else n_pass++;
        n_chk++; if (err !== 3'b100) $display("FAIL opmis_err: got %b want 100", err); else n_pass++;
        n_chk++; if (ov_t !== 9 || chain_cnt !== 16'd2 || out_op !== 1'b0) $display("FAIL opmis_result: got ov=%0d cnt=%0d op=%b want 9 2 0", ov_t, chain_cnt, out_op); else n_pass++;
        drain();
    endtask

    task automatic test_orphan_restart();
        drive_chain(2, 8'h00, 8'h02, 8'h02, 11, -1, 1'b1);
        n_chk++; if (iss_zero[0] !== 1'b1) $display("FAIL orphan_zero: got %b want 1", iss_zero[0]); else n_pass++;
        n_chk++; if (err_at1 !== 3'b001) $display("FAIL orphan_err_set_wins: got %b want 001", err_at1); else n_pass++;
        n_chk++; if (iss_t[1] !== 5 || iss_zero[1] !== 1'b1) $display("FAIL restart_issue: got t=%0d zero=%b want 5 1", iss_t[1], iss_zero[1]); else n_pass++;
        n_chk++; if (err !== 3'b011 || chain_cnt !== 16'd1) $display("FAIL restart_status: got err=%b cnt=%0d want 011 1", err, chain_cnt); else n_pass++;
        n_chk++; if (ov_t !== 9) $display("FAIL restart_ov_t: got %0d want 9", ov_t); else n_pass++;
        drain();
        err_clr = 1'b1;
        next();
        err_clr = 1'b0;
        #1;
        n_chk++; if (err !== 3'b000) $display("FAIL err_clr: got %b want 000", err); else n_pass++;
    endtask

    task automatic test_hold_backpressure();
        int ov_n, rdy_n, iss_n, we_n;
        ov_n = 0; rdy_n = 0; iss_n = 0; we_n = 0;
        drive_chain(1, 8'h01, 8'h01, 8'h01, 6, -1, 1'b0);
        n_chk++; if (ov_t !== 4) $display("FAIL hold_ov_t: got %0d want 4", ov_t); else n_pass++;
        in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1;
        for (int i = 0; i < 20; i++) begin
            next();
            if (out_valid) ov_n++;
            if (in_ready) rdy_n++;
            if (dp_issue) iss_n++;
            if (dp_acc_we) we_n++;
        end
        in_valid = 1'b0;
        n_chk++; if (ov_n !== 20 || rdy_n !== 0) $display("FAIL hold_held: got ov=%0d rdy=%0d want 20 0", ov_n, rdy_n); else n_pass++;
        n_chk++; if (iss_n !== 0 || we_n !== 0) $display("FAIL hold_quiet: got issue=%0d we=%0d want 0 0", iss_n, we_n); else n_pass++;
        drain();
        n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || chain_cnt !== 16'd1) $display("FAIL hold_release: got ov=%b rdy=%b cnt=%0d want 0 1 1", out_valid, in_ready, chain_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_reset_mid_run();
        test_single_chain();
        test_half_chain();
        test_op_mismatch();
        test_orphan_restart();
        test_hold_backpressure();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
